// File: rtl/sync_pkg.sv
// sync_pkg: shared constants and helpers for the sync_bank synchroniser slice.
//   SYNC_MIN_STAGES        - shortest chain that still gives metastability margin
//   SYNC_DEFAULT_DB_CYCLES - default debounce qualification length (clk cycles)
//   db_cnt_width(n)        - counter width able to hold the value n
package sync_pkg;

  localparam int SYNC_MIN_STAGES        = 2;
  localparam int SYNC_DEFAULT_DB_CYCLES = 16;

  function automatic int db_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_bank_if.sv
// sync_bank_if: pin-side bundle of the synchroniser bank.
//   async_in   - raw asynchronous level inputs, one bit per channel
//   level_out  - clean synchronised (optionally debounced) levels
//   rise_pulse - one-cycle pulse on a 0->1 change of level_out
//   fall_pulse - one-cycle pulse on a 1->0 change of level_out
// There is no handshake: async_in is a free-running level and the outputs are
// valid every clk cycle once reset is released.
// Modports: master = whoever drives the pins and consumes the outputs,
//           slave  = the sync_bank itself.
interface sync_bank_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output async_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  async_in,
    output level_out,
    output rise_pulse,
    output fall_pulse
  );

endinterface

// File: rtl/sync_chan.sv
// sync_chan: one channel of the synchroniser bank.
//   clk, reset_n - system clock, asynchronous active-low reset
//   async_in     - raw asynchronous level
//   level_out    - synchronised (optionally debounced) level
//   rise_pulse   - high for the first cycle of a new 1 level
//   fall_pulse   - high for the first cycle of a new 0 level
// Optional feature macro: SYNC_DEBOUNCE_EN adds a DB_CYCLES-long qualification
// filter between the synchroniser chain and the edge detector.
// Every flop loads RESET_VAL on reset so nothing toggles at reset release.
module sync_chan
  import sync_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0,
  parameter int   DB_CYCLES = SYNC_DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_chan: STAGES must be at least SYNC_MIN_STAGES");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("sync_chan: DB_CYCLES must be at least 1");
  end

  // Plain flop chain; nothing may sit between stages.
  logic [STAGES-1:0] chain;
  logic              sync_lvl;
  logic              level_d;
  logic              prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_lvl = chain[STAGES-1];

`ifdef SYNC_DEBOUNCE_EN
  localparam int            CW       = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          db;

  // The count only runs while sync disagrees with the filtered level; a bounce
  // back to db restarts it. Accepting on CNT_LAST means the change is taken on
  // the DB_CYCLES-th consecutive disagreeing cycle, so cnt never saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      db  <= RESET_VAL;
    end else if (sync_lvl == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      db  <= sync_lvl;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level_d = db;
`else
  assign level_d = sync_lvl;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= RESET_VAL;
    end else begin
      prev <= level_d;
    end
  end

  assign level_out  = level_d;
  assign rise_pulse = level_d & ~prev;
  assign fall_pulse = ~level_d & prev;

endmodule

// File: rtl/sync_bank.sv
// sync_bank: WIDTH independent clock-domain-crossing synchronisers for slow
// asynchronous level inputs (buttons, switches, MCU GPIO/handshake lines),
// each with rise/fall event pulses.
//   clk     - system clock
//   reset_n - asynchronous assert, synchronously released, active-low reset
//   bus     - sync_bank_if.slave: async_in in; level_out, rise_pulse,
//             fall_pulse out
// Optional feature macro: SYNC_DEBOUNCE_EN (per-channel debounce, DB_CYCLES).
// Channels are not coherent with each other: a multi-bit bus passed through
// here can be seen with bits from different cycles.
module sync_bank
  import sync_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               DB_CYCLES = SYNC_DEFAULT_DB_CYCLES
) (
  input  logic         clk,
  input  logic         reset_n,
  sync_bank_if.slave   bus
);

  logic [WIDTH-1:0] level_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_chan #(
      .STAGES    (STAGES),
      .RESET_VAL (RESET_VAL[i]),
      .DB_CYCLES (DB_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_in   (bus.async_in[i]),
      .level_out  (level_v[i]),
      .rise_pulse (rise_v[i]),
      .fall_pulse (fall_v[i])
    );
  end

  assign bus.level_out  = level_v;
  assign bus.rise_pulse = rise_v;
  assign bus.fall_pulse = fall_v;

endmodule

// File: tb/tb_sync_bank.sv
// tb_sync_bank: directed, scoreboard-checked bench for sync_bank.
// Four instances share clk/reset_n:
//   a: STAGES=2, RESET_VAL=0000     b: STAGES=3, RESET_VAL=0000
//   c: STAGES=2, RESET_VAL=0100     d: STAGES=2, RESET_VAL=0000, DB_CYCLES=4
// Default build runs the non-debounce scenarios; with SYNC_DEBOUNCE_EN the
// debounce scenarios run on instance d.
// Observed word = {level_out, rise_pulse, fall_pulse}. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
module tb_sync_bank;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  sync_bank_if #(.WIDTH(W)) if_a ();
  sync_bank_if #(.WIDTH(W)) if_b ();
  sync_bank_if #(.WIDTH(W)) if_c ();
  sync_bank_if #(.WIDTH(W)) if_d ();

  sync_bank #(.WIDTH(W), .STAGES(2), .RESET_VAL(4'b0000), .DB_CYCLES(4))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  sync_bank #(.WIDTH(W), .STAGES(3), .RESET_VAL(4'b0000), .DB_CYCLES(4))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  sync_bank #(.WIDTH(W), .STAGES(2), .RESET_VAL(4'b0100), .DB_CYCLES(4))
    dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));
  sync_bank #(.WIDTH(W), .STAGES(2), .RESET_VAL(4'b0000), .DB_CYCLES(4))
    dut_d (.clk(clk), .reset_n(reset_n), .bus(if_d));

  // Scoreboard
  logic [3*W-1:0] exp_q[$];
  string          tag_q[$];
  int             checks = 0;
  int             errors = 0;

  function automatic logic [3*W-1:0] pk(input logic [W-1:0] l,
                                        input logic [W-1:0] r,
                                        input logic [W-1:0] f);
    return {l, r, f};
  endfunction

  function automatic logic [3*W-1:0] obs(input int sel);
    case (sel)
      0:       return {if_a.level_out, if_a.rise_pulse, if_a.fall_pulse};
      1:       return {if_b.level_out, if_b.rise_pulse, if_b.fall_pulse};
      2:       return {if_c.level_out, if_c.rise_pulse, if_c.fall_pulse};
      default: return {if_d.level_out, if_d.rise_pulse, if_d.fall_pulse};
    endcase
  endfunction

  task automatic check_pop(input int sel);
    logic [3*W-1:0] e;
    logic [3*W-1:0] o;
    string          t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = obs(sel);
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (level_rise_fall)", t, o, e);
    end
  endtask

  // Expect e after the next rising edge.
  task automatic step(input int sel, input logic [3*W-1:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    @(negedge clk);
    check_pop(sel);
  endtask

  // Expect e right now, with no clock edge in between.
  task automatic now_chk(input int sel, input logic [3*W-1:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    check_pop(sel);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_a.async_in = 4'b0000;
    if_b.async_in = 4'b0000;
    if_c.async_in = 4'b0100;
    if_d.async_in = 4'b0000;
    reset_n       = 1'b0;
    @(negedge clk);
    @(negedge clk);

`ifndef SYNC_DEBOUNCE_EN
    // Reset hold and first edge after release.
    if_a.async_in = 4'b1010;
    now_chk(0, pk(4'b0000, 4'b0000, 4'b0000), "t1_in_reset_a");
    step   (0, pk(4'b0000, 4'b0000, 4'b0000), "t1_in_reset_edge_a");
    now_chk(2, pk(4'b0100, 4'b0000, 4'b0000), "t1_in_reset_c");
    reset_n = 1'b1;
    step(0, pk(4'b0000, 4'b0000, 4'b0000), "t1_edge1");
    step(0, pk(4'b1010, 4'b1010, 4'b0000), "t1_edge2");
    step(0, pk(4'b1010, 4'b0000, 4'b0000), "t1_edge3");
    step(0, pk(4'b1010, 4'b0000, 4'b0000), "t1_edge4");

    // Non-zero reset value: quiet after release, then one fall pulse.
    reset_pulse();
    for (int i = 0; i < 20; i++) begin
      step(2, pk(4'b0100, 4'b0000, 4'b0000), $sformatf("t3_quiet_%0d", i));
    end
    if_c.async_in = 4'b0000;
    step(2, pk(4'b0100, 4'b0000, 4'b0000), "t3_edge1");
    step(2, pk(4'b0000, 4'b0000, 4'b0100), "t3_edge2");
    step(2, pk(4'b0000, 4'b0000, 4'b0000), "t3_edge3");

    // Three-stage chain latency.
    if_b.async_in = 4'b0001;
    step(1, pk(4'b0000, 4'b0000, 4'b0000), "t2_edge1");
    step(1, pk(4'b0000, 4'b0000, 4'b0000), "t2_edge2");
    step(1, pk(4'b0001, 4'b0001, 4'b0000), "t2_edge3");
    step(1, pk(4'b0001, 4'b0000, 4'b0000), "t2_edge4");

    // Simultaneous rise on bit0 and fall on bit1.
    if_a.async_in = 4'b1001;
    step(0, pk(4'b1010, 4'b0000, 4'b0000), "t5_edge1");
    step(0, pk(4'b1001, 4'b0001, 4'b0010), "t5_edge2");
    step(0, pk(4'b1001, 4'b0000, 4'b0000), "t5_edge3");

    // Mid-operation reset with a change still inside the chain.
    if_a.async_in = 4'b0110;
    step(0, pk(4'b1001, 4'b0000, 4'b0000), "t6_pending");
    reset_n = 1'b0;
    #1;
    now_chk(0, pk(4'b0000, 4'b0000, 4'b0000), "t6_async_a");
    now_chk(2, pk(4'b0100, 4'b0000, 4'b0000), "t6_async_c");
    if_a.async_in = 4'b0000;
    if_c.async_in = 4'b0100;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step   (0, pk(4'b0000, 4'b0000, 4'b0000), $sformatf("t6_after_a_%0d", i));
      now_chk(2, pk(4'b0100, 4'b0000, 4'b0000), $sformatf("t6_after_c_%0d", i));
    end
`else
    now_chk(3, pk(4'b0000, 4'b0000, 4'b0000), "t4_in_reset_d");
    reset_n = 1'b1;
    step(3, pk(4'b0000, 4'b0000, 4'b0000), "t4_idle0");
    step(3, pk(4'b0000, 4'b0000, 4'b0000), "t4_idle1");

    // Three-cycle glitch on bit2 never qualifies.
    if_d.async_in = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step(3, pk(4'b0000, 4'b0000, 4'b0000), $sformatf("t4_glitch_%0d", i));
    end
    if_d.async_in = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      step(3, pk(4'b0000, 4'b0000, 4'b0000), $sformatf("t4_settle_%0d", i));
    end

    // Held high: accepted on the 6th edge, single rise pulse.
    if_d.async_in = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step(3, pk(4'b0000, 4'b0000, 4'b0000), $sformatf("t4_qual_%0d", i));
    end
    step(3, pk(4'b0100, 4'b0100, 4'b0000), "t4_accept");
    for (int i = 0; i < 4; i++) begin
      step(3, pk(4'b0100, 4'b0000, 4'b0000), $sformatf("t4_hold_%0d", i));
    end

    // Reset while bit1's counter sits at 3 of 4.
    if_d.async_in = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      step(3, pk(4'b0100, 4'b0000, 4'b0000), $sformatf("t6_count_%0d", i));
    end
    reset_n = 1'b0;
    #1;
    now_chk(3, pk(4'b0000, 4'b0000, 4'b0000), "t6_async_d");
    if_d.async_in = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(3, pk(4'b0000, 4'b0000, 4'b0000), $sformatf("t6_after_d_%0d", i));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
